// File: rtl/neural_network.sv
// neural_network: two-layer fully connected inference engine, 10 neurons per layer.
// It runs once after each reset release.
//   Layer 1: one input index per cycle, all 10 neurons MAC in parallel.
//            Then bias, ReLU and saturation to LAYER1_BITS+1 signed bits.
//   Layer 2: the 10 hidden activations feed 10 signed logits.
//            Then bias and saturation to LAYER2_BITS+9 signed bits.
// Ports:
//   clk            rising-edge clock
//   rstn           asynchronous active-low reset; clears every register
//   b1, b2         layer-1 (32-bit) and layer-2 (64-bit) biases
//   data_in        input vector, sampled combinationally while layer 1 runs
//   w1_1..w1_10    layer-1 weights per neuron
//   w2_1..w2_10    layer-2 weights per neuron
//   neuralnet_out  10 saturated logits; 0 until the result edge, then held
// Optional macro NN_OUT_RELU_EN: clamps negative logits to 0 before saturation.
module neural_network #(
  parameter int LAYER1_NEURON_WIDTH = 823,
  parameter int LAYER1_COUNTER_END  = 820,
  parameter int LAYER1_BITS         = 31,
  parameter int LAYER2_NEURON_WIDTH = 49,
  parameter int LAYER2_COUNTER_END  = 40,
  parameter int LAYER2_BITS         = LAYER1_BITS + 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic signed [31:0]            b1            [0:9],
  input  logic signed [63:0]            b2            [0:9],
  input  logic signed [31:0]            data_in       [0:LAYER1_NEURON_WIDTH],
  input  logic signed [31:0]            w1_1          [0:LAYER1_NEURON_WIDTH],
  input  logic signed [31:0]            w1_2          [0:LAYER1_NEURON_WIDTH],
  input  logic signed [31:0]            w1_3          [0:LAYER1_NEURON_WIDTH],
  input  logic signed [31:0]            w1_4          [0:LAYER1_NEURON_WIDTH],
  input  logic signed [31:0]            w1_5          [0:LAYER1_NEURON_WIDTH],
  input  logic signed [31:0]            w1_6          [0:LAYER1_NEURON_WIDTH],
  input  logic signed [31:0]            w1_7          [0:LAYER1_NEURON_WIDTH],
  input  logic signed [31:0]            w1_8          [0:LAYER1_NEURON_WIDTH],
  input  logic signed [31:0]            w1_9          [0:LAYER1_NEURON_WIDTH],
  input  logic signed [31:0]            w1_10         [0:LAYER1_NEURON_WIDTH],
  input  logic signed [31:0]            w2_1          [0:LAYER2_NEURON_WIDTH],
  input  logic signed [31:0]            w2_2          [0:LAYER2_NEURON_WIDTH],
  input  logic signed [31:0]            w2_3          [0:LAYER2_NEURON_WIDTH],
  input  logic signed [31:0]            w2_4          [0:LAYER2_NEURON_WIDTH],
  input  logic signed [31:0]            w2_5          [0:LAYER2_NEURON_WIDTH],
  input  logic signed [31:0]            w2_6          [0:LAYER2_NEURON_WIDTH],
  input  logic signed [31:0]            w2_7          [0:LAYER2_NEURON_WIDTH],
  input  logic signed [31:0]            w2_8          [0:LAYER2_NEURON_WIDTH],
  input  logic signed [31:0]            w2_9          [0:LAYER2_NEURON_WIDTH],
  input  logic signed [31:0]            w2_10         [0:LAYER2_NEURON_WIDTH],
  output logic signed [LAYER2_BITS+8:0] neuralnet_out [0:9]
);

  localparam int H_W    = LAYER1_BITS + 1;
  localparam int OUT_W  = LAYER2_BITS + 9;
  localparam int ACC1_W = 74;
  localparam int ACC2_W = 72;
  localparam int S1_W   = ACC1_W + 1;
  localparam int S2_W   = ACC2_W + 1;
  localparam int P2_W   = H_W + 32;
  localparam int I_W    = $clog2(LAYER1_NEURON_WIDTH + 1);
  localparam int K_W    = $clog2(LAYER2_NEURON_WIDTH + 1);

  localparam logic signed [S1_W-1:0] H_MAX = {{(S1_W-H_W+1){1'b0}}, {(H_W-1){1'b1}}};
  localparam logic signed [S2_W-1:0] O_MAX = {{(S2_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [S2_W-1:0] O_MIN = {{(S2_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, L1, L1_FIN, L2, L2_FIN, DONE} state_t;

  state_t state, state_nxt;
  logic   mac1_en, fin1_en, mac2_en, fin2_en;

  logic [I_W-1:0]           i_cnt;
  logic [K_W-1:0]           k_cnt;
  logic signed [ACC1_W-1:0] acc1 [0:9];
  logic signed [ACC2_W-1:0] acc2 [0:9];
  logic signed [H_W-1:0]    h    [0:9];

  logic signed [31:0]       data_sel;
  logic signed [H_W-1:0]    x_sel;
  logic signed [31:0]       w1_sel [0:9];
  logic signed [31:0]       w2_sel [0:9];
  logic signed [63:0]       prod1  [0:9];
  logic signed [P2_W-1:0]   prod2  [0:9];

  // Hidden activation: ReLU, then clamp to the positive range of H_W bits.
  function automatic logic signed [H_W-1:0] relu_sat_h(input logic signed [S1_W-1:0] v);
    if (v < 0)          return '0;
    else if (v > H_MAX) return H_MAX[H_W-1:0];
    else                return v[H_W-1:0];
  endfunction

  // Logit: symmetric saturation to OUT_W signed bits (optionally ReLU first).
  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [S2_W-1:0] v);
`ifdef NN_OUT_RELU_EN
    if (v < 0)          return '0;
    else if (v > O_MAX) return O_MAX[OUT_W-1:0];
    else                return v[OUT_W-1:0];
`else
    if (v > O_MAX)      return O_MAX[OUT_W-1:0];
    else if (v < O_MIN) return O_MIN[OUT_W-1:0];
    else                return v[OUT_W-1:0];
`endif
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = L1;
      L1:      if (i_cnt == I_W'(LAYER1_COUNTER_END)) state_nxt = L1_FIN;
      L1_FIN:  state_nxt = L2;
      L2:      if (k_cnt == K_W'(LAYER2_COUNTER_END)) state_nxt = L2_FIN;
      L2_FIN:  state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mac1_en = (state == L1);
    fin1_en = (state == L1_FIN);
    mac2_en = (state == L2);
    fin2_en = (state == L2_FIN);
  end

  // Operand selection: the counters index the static input arrays directly.
  // Hidden indices past 9 contribute zero, so w2 entries above 9 never matter.
  always_comb begin
    data_sel  = data_in[i_cnt];
    w1_sel[0] = w1_1[i_cnt];  w1_sel[1] = w1_2[i_cnt];  w1_sel[2] = w1_3[i_cnt];
    w1_sel[3] = w1_4[i_cnt];  w1_sel[4] = w1_5[i_cnt];  w1_sel[5] = w1_6[i_cnt];
    w1_sel[6] = w1_7[i_cnt];  w1_sel[7] = w1_8[i_cnt];  w1_sel[8] = w1_9[i_cnt];
    w1_sel[9] = w1_10[i_cnt];
    x_sel     = (k_cnt <= K_W'(9)) ? h[k_cnt[3:0]] : '0;
    w2_sel[0] = w2_1[k_cnt];  w2_sel[1] = w2_2[k_cnt];  w2_sel[2] = w2_3[k_cnt];
    w2_sel[3] = w2_4[k_cnt];  w2_sel[4] = w2_5[k_cnt];  w2_sel[5] = w2_6[k_cnt];
    w2_sel[6] = w2_7[k_cnt];  w2_sel[7] = w2_8[k_cnt];  w2_sel[8] = w2_9[k_cnt];
    w2_sel[9] = w2_10[k_cnt];
    for (int j = 0; j < 10; j++) begin
      prod1[j] = 64'(data_sel) * 64'(w1_sel[j]);
      prod2[j] = P2_W'(x_sel) * P2_W'(w2_sel[j]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      i_cnt <= '0;
      k_cnt <= '0;
      for (int j = 0; j < 10; j++) begin
        acc1[j]          <= '0;
        acc2[j]          <= '0;
        h[j]             <= '0;
        neuralnet_out[j] <= '0;
      end
    end else begin
      // Layer-1 MAC: one input index per cycle
      if (mac1_en) begin
        i_cnt <= i_cnt + 1'b1;
        for (int j = 0; j < 10; j++) acc1[j] <= acc1[j] + ACC1_W'(prod1[j]);
      end
      // Layer-1 finish: bias, ReLU, saturate; prepare layer 2
      if (fin1_en) begin
        k_cnt <= '0;
        for (int j = 0; j < 10; j++) begin
          h[j]    <= relu_sat_h(S1_W'(acc1[j]) + S1_W'(b1[j]));
          acc2[j] <= '0;
        end
      end
      // Layer-2 MAC: one hidden index per cycle
      if (mac2_en) begin
        k_cnt <= k_cnt + 1'b1;
        for (int j = 0; j < 10; j++) acc2[j] <= acc2[j] + ACC2_W'(prod2[j]);
      end
      // Layer-2 finish: bias and saturate into the held output
      if (fin2_en) begin
        for (int j = 0; j < 10; j++)
          neuralnet_out[j] <= sat_out(S2_W'(acc2[j]) + S2_W'(b2[j]));
      end
    end
  end

endmodule

// File: tb/tb_neural_network.sv
// tb_neural_network: directed self-checking bench for neural_network.
// Each scenario programs the operand arrays, releases reset and checks the
// logits against hand-computed constants on the result edge.
module tb_neural_network;

  localparam logic signed [63:0] MAX32 = 64'sd2147483647;
  localparam logic signed [63:0] OMAX  = 64'sd140737488355327;
  localparam logic signed [63:0] OMIN  = -64'sd140737488355328;

  logic clk;
  logic rstn;
  logic signed [31:0] b1 [0:9];
  logic signed [63:0] b2 [0:9];
  logic signed [31:0] data_in [0:823];
  logic signed [31:0] w1_1 [0:823], w1_2 [0:823], w1_3 [0:823], w1_4 [0:823], w1_5 [0:823];
  logic signed [31:0] w1_6 [0:823], w1_7 [0:823], w1_8 [0:823], w1_9 [0:823], w1_10 [0:823];
  logic signed [31:0] w2_1 [0:49], w2_2 [0:49], w2_3 [0:49], w2_4 [0:49], w2_5 [0:49];
  logic signed [31:0] w2_6 [0:49], w2_7 [0:49], w2_8 [0:49], w2_9 [0:49], w2_10 [0:49];
  logic signed [47:0] nn_out [0:9];

  logic signed [63:0] exp_out [0:9];
  int n_checks;
  int n_errors;

  neural_network dut (
    .clk(clk), .rstn(rstn), .b1(b1), .b2(b2), .data_in(data_in),
    .w1_1(w1_1), .w1_2(w1_2), .w1_3(w1_3), .w1_4(w1_4), .w1_5(w1_5),
    .w1_6(w1_6), .w1_7(w1_7), .w1_8(w1_8), .w1_9(w1_9), .w1_10(w1_10),
    .w2_1(w2_1), .w2_2(w2_2), .w2_3(w2_3), .w2_4(w2_4), .w2_5(w2_5),
    .w2_6(w2_6), .w2_7(w2_7), .w2_8(w2_8), .w2_9(w2_9), .w2_10(w2_10),
    .neuralnet_out(nn_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  task automatic check_all(input string tag);
    for (int j = 0; j < 10; j++)
      check($sformatf("%s_out%0d", tag, j), 64'(nn_out[j]), exp_out[j]);
  endtask

  task automatic set_w1(input int j, input int idx, input logic signed [31:0] v);
    case (j)
      0: w1_1[idx] = v;  1: w1_2[idx] = v;  2: w1_3[idx] = v;  3: w1_4[idx] = v;
      4: w1_5[idx] = v;  5: w1_6[idx] = v;  6: w1_7[idx] = v;  7: w1_8[idx] = v;
      8: w1_9[idx] = v;  default: w1_10[idx] = v;
    endcase
  endtask

  task automatic set_w2(input int j, input int idx, input logic signed [31:0] v);
    case (j)
      0: w2_1[idx] = v;  1: w2_2[idx] = v;  2: w2_3[idx] = v;  3: w2_4[idx] = v;
      4: w2_5[idx] = v;  5: w2_6[idx] = v;  6: w2_7[idx] = v;  7: w2_8[idx] = v;
      8: w2_9[idx] = v;  default: w2_10[idx] = v;
    endcase
  endtask

  task automatic fill_w1(input int j, input logic signed [31:0] v);
    for (int i = 0; i < 824; i++) set_w1(j, i, v);
  endtask

  task automatic fill_data(input logic signed [31:0] v);
    for (int i = 0; i < 824; i++) data_in[i] = v;
  endtask

  task automatic clear_all();
    fill_data(32'sd0);
    for (int j = 0; j < 10; j++) begin
      fill_w1(j, 32'sd0);
      for (int k = 0; k < 50; k++) set_w2(j, k, 32'sd0);
      b1[j] = '0;
      b2[j] = '0;
      exp_out[j] = '0;
    end
  endtask

  // Reset, release on a falling edge, then count rising edges.  The result
  // lands on edge 865 after release (the cycle numbered 866 in the test plan).
  task automatic run_and_check(input string tag);
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (864) @(posedge clk);
    #1;
    check({tag, "_early"}, 64'(nn_out[0]), 64'sd0);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rstn = 1'b0;

    // Reset hold with arbitrary operands
    for (int i = 0; i < 824; i++) data_in[i] = $urandom;
    for (int j = 0; j < 10; j++) begin
      for (int i = 0; i < 824; i++) set_w1(j, i, $urandom);
      for (int k = 0; k < 50; k++) set_w2(j, k, $urandom);
      b1[j] = $urandom;
      b2[j] = {$urandom, $urandom};
      exp_out[j] = '0;
    end
    repeat (20) @(posedge clk);
    #1;
    check_all("rst_hold");

    // Unit test: h[0] = 821 ones, every logit copies h[0]
    clear_all();
    fill_data(32'sd1);
    fill_w1(0, 32'sd1);
    for (int j = 0; j < 10; j++) begin
      set_w2(j, 0, 32'sd1);
      exp_out[j] = 64'sd821;
    end
    run_and_check("unit");

    // Asynchronous reset clears the held result without a clock edge
    #3;
    rstn = 1'b0;
    #1;
    for (int j = 0; j < 10; j++) check($sformatf("async_clr%0d", j), 64'(nn_out[j]), 64'sd0);

    // Reset in the middle of layer 1, then a full restart
    @(negedge clk);
    rstn = 1'b1;
    repeat (400) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("mid_l1_rst", 64'(nn_out[0]), 64'sd0);
    run_and_check("restart");

    // Entries past the counter ends are ignored
    for (int i = 821; i < 824; i++) data_in[i] = 32'sh7FFFFFFF;
    for (int j = 0; j < 10; j++)
      for (int k = 10; k < 50; k++) set_w2(j, k, 32'sh12345678);
    run_and_check("ignored");

    // ReLU on hidden layer plus layer-1 / layer-2 biases
    clear_all();
    fill_data(32'sd1);
    fill_w1(0, -32'sd1);
    b1[0] = 32'sd5;             // h[0] = ReLU(-821 + 5) = 0
    b1[1] = 32'sd9;             // h[1] = 9 from bias alone
    set_w2(0, 0, 32'sd1);       // out[0] = h[0] = 0
    set_w2(1, 1, 32'sd3);       // out[1] = 3 * 9 = 27
    set_w2(3, 0, 32'sd1);
    b2[3] = -64'sd7;            // out[3] = 0 - 7
    b2[5] = 64'sd100;           // out[5] = 100
    exp_out[1] = 64'sd27;
    exp_out[5] = 64'sd100;
`ifdef NN_OUT_RELU_EN
    exp_out[3] = 64'sd0;
`else
    exp_out[3] = -64'sd7;
`endif
    run_and_check("relu_bias");

    // Positive saturation: every h clamps to 0x7FFFFFFF
    clear_all();
    fill_data(32'sh7FFFFFFF);
    for (int j = 0; j < 10; j++) fill_w1(j, 32'sh7FFFFFFF);
    for (int k = 0; k < 10; k++) set_w2(0, k, 32'sh7FFFFFFF);
    for (int j = 1; j < 10; j++) begin
      set_w2(j, j, 32'sd1);
      exp_out[j] = MAX32;
    end
    exp_out[0] = OMAX;
    run_and_check("sat_pos");

    // Negative saturation mirror on logit 0
    for (int k = 0; k < 10; k++) set_w2(0, k, 32'sh80000000);
`ifdef NN_OUT_RELU_EN
    exp_out[0] = 64'sd0;
`else
    exp_out[0] = OMIN;
`endif
    run_and_check("sat_neg");

    // Hold in DONE while operands keep changing
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      for (int r = 0; r < 8; r++) begin
        data_in[$urandom_range(823, 0)] = $urandom;
        w1_1[$urandom_range(823, 0)]    = $urandom;
        w2_1[$urandom_range(49, 0)]     = $urandom;
      end
      if (c == 250) check("hold_mid", 64'(nn_out[0]), exp_out[0]);
    end
    @(posedge clk);
    #1;
    check_all("hold");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
